// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates one bouncy press/release of an active-low push-button per start request.
// Define KEY_BOUNCE_LFSR_EN for pseudo-random bounce segments; otherwise every segment is BOUNCE_MASK+1 cycles.
module key_bounce_gen #(
  parameter int          BOUNCE_PAIRS = 2,
  parameter logic [15:0] BOUNCE_MASK  = 16'h0003,
  parameter int          HOLD_W       = 24,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              key_out,
  output logic              busy,
  output logic              done
);
  localparam int SEG_W = 17;
  localparam int TW = $clog2(2 * BOUNCE_PAIRS + 2);
  localparam logic [TW-1:0] TOG_LAST = TW'(2 * BOUNCE_PAIRS - 1);
  typedef enum logic [2:0] {IDLE, PRESS_B, HOLD, REL_B, DONE} state_t;
  state_t state_q, state_d;
  logic key_q, key_d, busy_q, busy_d, done_q, done_d;
  logic [SEG_W-1:0] seg_q, seg_d, seg_len;
  logic [TW-1:0] tog_q, tog_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk)
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign seg_len = {1'b0, lfsr_q & BOUNCE_MASK} + SEG_W'(1);
`else
  assign seg_len = {1'b0, BOUNCE_MASK} + SEG_W'(1);
`endif
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    seg_d = seg_q;
    tog_d = tog_q;
    hold_d = hold_q;
    case (state_q)
      IDLE, DONE: begin
        key_d = 1'b1;
        state_d = IDLE;
        if (start) begin
          key_d = 1'b0;
          seg_d = seg_len;
          tog_d = '0;
          hold_d = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          state_d = (BOUNCE_PAIRS == 0) ? HOLD : PRESS_B;
        end
      end
      PRESS_B, REL_B: begin
        // the toggle that completes a burst hands over immediately, so the next level starts cleanly
        if (seg_q == SEG_W'(1)) begin
          key_d = ~key_q;
          tog_d = tog_q + TW'(1);
          seg_d = seg_len;
          if (tog_q == TOG_LAST) state_d = (state_q == PRESS_B) ? HOLD : DONE;
        end else seg_d = seg_q - SEG_W'(1);
      end
      HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          key_d = 1'b1;
          seg_d = seg_len;
          tog_d = '0;
          state_d = (BOUNCE_PAIRS == 0) ? DONE : REL_B;
        end else hold_d = hold_q - HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {PRESS_B, HOLD, REL_B};
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      key_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seg_q <= '0;
      tog_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      busy_q <= busy_d;
      done_q <= done_d;
      seg_q <= seg_d;
      tog_q <= tog_d;
      hold_q <= hold_d;
    end
  assign key_out = key_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: directed checks of key_bounce_gen waveforms, start filtering and reset.
module tb_key_bounce_gen;
  logic clk = 1'b0;
  logic rst_n, start, start0;
  logic [23:0] hold_cycles, hold0;
  logic key_out, busy, done, key0, busy0, done0;
  int checks = 0;
  int errors = 0;
  key_bounce_gen dut (.clk(clk), .rst_n(rst_n), .start(start), .hold_cycles(hold_cycles),
                      .key_out(key_out), .busy(busy), .done(done));
  key_bounce_gen #(.BOUNCE_PAIRS(0)) dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .hold_cycles(hold0),
                      .key_out(key0), .busy(busy0), .done(done0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_key(int c);
    return !((c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 26) ||
             (c >= 31 && c <= 34) || (c >= 39 && c <= 42));
  endfunction
`ifndef KEY_BOUNCE_LFSR_EN
  task automatic press(input int restart_at);
    int dn;
    dn = 0;
    start = 1'b1;
    hold_cycles = 24'd10;
    tick();
    for (int c = 1; c <= 45; c++) begin
      start = (c == restart_at);
      if (c == 2) hold_cycles = 24'd3;
      chk($sformatf("key c%0d", c), key_out, exp_key(c));
      chk($sformatf("busy c%0d", c), busy, c >= 1 && c <= 42);
      chk($sformatf("done c%0d", c), done, c == 43);
      dn += int'(done);
      tick();
    end
    start = 1'b0;
    chk("done_count", dn, 1);
  endtask
`endif
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start0 = 1'b0;
    hold_cycles = '0;
    hold0 = '0;
    repeat (2) tick();
    chk("rst key", key_out, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst key0", key0, 1);
    rst_n = 1'b1;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("p0 key c1", key0, 0);
    chk("p0 busy c1", busy0, 1);
    chk("p0 done c1", done0, 0);
    tick();
    chk("p0 key c2", key0, 1);
    chk("p0 busy c2", busy0, 0);
    chk("p0 done c2", done0, 1);
    tick();
    chk("p0 done c3", done0, 0);
`ifndef KEY_BOUNCE_LFSR_EN
    press(0);
    press(5);
    start = 1'b1;
    hold_cycles = 24'd10;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("pre-rst key c20", key_out, 0);
    chk("pre-rst busy c20", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("mid-rst key c21", key_out, 1);
    chk("mid-rst busy c21", busy, 0);
    chk("mid-rst done c21", done, 0);
    rst_n = 1'b1;
    tick();
    press(0);
`else
    begin
      int runs[16];
      int cnt, len, h, bad, c;
      logic prev;
      start = 1'b1;
      h = $urandom_range(1, 50);
      hold_cycles = 24'(h);
      for (int p = 0; p < 200; p++) begin
        tick();
        start = 1'b0;
        prev = key_out;
        len = 1;
        cnt = 0;
        c = 1;
        while (!done && c < 200) begin
          tick();
          c++;
          if (!done) begin
            if (key_out == prev) len++;
            else begin
              if (cnt < 16) runs[cnt] = len;
              cnt++;
              prev = key_out;
              len = 1;
            end
          end
        end
        chk($sformatf("press%0d done", p), done, 1);
        if (cnt < 16) runs[cnt] = len;
        cnt++;
        chk($sformatf("press%0d runs", p), cnt, 9);
        bad = 0;
        for (int i = 0; i < 9 && i < cnt; i++)
          if (i != 4 && (runs[i] < 1 || runs[i] > 4)) bad++;
        chk($sformatf("press%0d seg_range", p), bad, 0);
        chk($sformatf("press%0d hold", p), runs[4], h);
        if (p < 199) begin
          start = 1'b1;
          h = $urandom_range(1, 50);
          hold_cycles = 24'(h);
        end
      end
      tick();
      chk("final idle busy", busy, 0);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable mechanical-key emulator: on a start request it drives one complete press/release of an active-low push-button, including contact bounce on both edges. It is the transmit end of the key path. Its `key_out` feeds a key debounce filter's `key_in` in on-board self-test and loopback builds, replacing a physical button. A press is a bounce burst falling to 0, a programmable stable hold, then a bounce burst rising back to 1.

## Interface
- `BOUNCE_PAIRS`, 2: glitch pairs per bounce burst. Each burst has 2×BOUNCE_PAIRS toggles; 0 gives clean edges.
- `BOUNCE_MASK`, 16'h0003: segment-length mask; segment length is (value & BOUNCE_MASK)+1 cycles.
- `HOLD_W`, 24: width of `hold_cycles`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: single-cycle press request; honoured only while `busy`=0.
- `hold_cycles` in HOLD_W: stable-low duration, captured when `start` is accepted.
- `key_out` out 1: emulated key level; idle/released = 1, pressed = 0.
- `busy` out 1: high while a press is in progress.
- `done` out 1: single-cycle pulse when the press completes.

## Operation
- States: IDLE, PRESS_B, HOLD, REL_B, DONE.
- IDLE: `key_out`=1 and `busy`=0. When `start`=1: capture `hold_cycles`, with 0 forced to 1. Set `key_out`<=0, load the segment counter, clear the toggle counter, and go to PRESS_B.
- PRESS_B: `key_out` holds each level for exactly one segment length.
  - At segment end, if toggles < 2×BOUNCE_PAIRS: toggle `key_out`, increment the toggle count, reload the segment counter.
  - Otherwise go to HOLD.
  - The last toggle always leaves `key_out`=0 because the toggle count is even.
  - With BOUNCE_PAIRS=0, go straight to HOLD.
- Segment length: (LFSR[15:0] & BOUNCE_MASK)+1, or BOUNCE_MASK+1 when the LFSR is compiled out (see Configuration).
- HOLD: `key_out`=0 stable for exactly the captured hold length, counted from the cycle after the last press toggle. Then set `key_out`<=1, clear the toggle counter, and go to REL_B.
- REL_B: same bounce rules as PRESS_B, starting from 1 and ending at 1. On completion go to DONE.
- DONE: one cycle with `done`=1, `busy`=0 and `key_out`=1, then go to IDLE. `start` is accepted in DONE, in which case DONE goes straight to PRESS_B.
- `start` while `busy`=1 is ignored, not queued. `hold_cycles` changes after capture have no effect.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state, and a new value is sampled at each segment load.

## Timing
- Reset (synchronous; takes effect at the first `clk` edge with `rst_n`=0, including mid-press):
  - `key_out`=1, `busy`=0, `done`=0.
  - State = IDLE; counters = 0; LFSR = LFSR_SEED.
- `start` sampled high in cycle 0 → `key_out`=0 and `busy`=1 in cycle 1. No other latency.
- `busy` is registered; it goes low in the same cycle `done` pulses.
- Total busy cycles = 2×Σ(bounce segments) + hold. With no LFSR, this is 2×(2×BOUNCE_PAIRS×(BOUNCE_MASK+1)) + hold.
- Minimum segment is 1 cycle, so `key_out` never holds a level for 0 cycles. The maximum segment is BOUNCE_MASK+1.
- HOLD counter width is HOLD_W. The maximum hold is 2^HOLD_W−1 cycles, with no wrap.

## Configuration
- Macro `KEY_BOUNCE_LFSR_EN`.
- Defined: segment lengths are pseudo-random in 1..BOUNCE_MASK+1, drawn from the LFSR.
- Undefined: the LFSR logic is removed, and every segment is exactly BOUNCE_MASK+1 cycles, giving a deterministic waveform.

## Test plan
- Macro undefined, defaults, `hold_cycles`=10, `start` in cycle 0:
  - `key_out`: 0 in cycles 1–4, 1 in 5–8, 0 in 9–12, 1 in 13–16, 0 in 17–26.
  - Release: 1 in 27–30, 0 in 31–34, 1 in 35–38, 0 in 39–42.
  - From cycle 43: `key_out`=1 and `done`=1 for 1 cycle; `busy`=1 for cycles 1–42.
- Macro undefined, BOUNCE_PAIRS=0, `hold_cycles`=0 → `key_out`=0 for exactly 1 cycle (cycle 1), then `done` in cycle 2.
- `start` pulsed in cycles 0 and 5 (`busy`=1 at cycle 5) → only one press is generated, and `done` pulses once.
- `rst_n`=0 in cycle 20 (during HOLD) → in cycle 21 `key_out`=1, `busy`=0, `done`=0. A `start` after reset then yields the exact waveform of test 1, time-shifted.
- Macro defined, 200 back-to-back presses, each started in the `done` cycle, with random `hold_cycles` 1..50:
  - Each press shows exactly 4 edges per bounce burst.
  - Every segment is 1–4 cycles long.
  - Stable low equals the captured hold.
- Loopback to a debounce filter with a shortened settle time → exactly one press flag and one release flag per generated press.
